// File: rtl/alarm_led_pkg.sv
// rtl/alarm_led_pkg.sv - shared types, mode encodings and LED pattern helpers
package alarm_led_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ALARM    = 2'd1,
    LATCHED  = 2'd2,
    SILENCED = 2'd3
  } state_t;

  localparam logic [1:0] MODE_STEADY = 2'd0;
  localparam logic [1:0] MODE_BLINK  = 2'd1;
  localparam logic [1:0] MODE_CHASE  = 2'd2;
  localparam logic [1:0] MODE_ALT    = 2'd3;

  localparam logic [9:0] PAT_ALL    = 10'h3FF;
  localparam logic [9:0] PAT_CHASE0 = 10'h001;
  localparam logic [9:0] PAT_ALT0   = 10'h155;

  function automatic logic [9:0] pat_init(input logic [1:0] m);
    case (m)
      MODE_CHASE: pat_init = PAT_CHASE0;
      MODE_ALT:   pat_init = PAT_ALT0;
      default:    pat_init = PAT_ALL;
    endcase
  endfunction

  // Chase rotates left so led_j wraps back to led_a.
  function automatic logic [9:0] pat_step(input logic [1:0] m, input logic [9:0] p);
    case (m)
      MODE_STEADY: pat_step = p;
      MODE_CHASE:  pat_step = {p[8:0], p[9]};
      default:     pat_step = ~p;
    endcase
  endfunction

endpackage

// File: rtl/alarm_tick_gen.sv
// rtl/alarm_tick_gen.sv - pattern step prescaler, one tick every TICK_DIV cycles
module alarm_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign tick = en && (count == LAST);

endmodule

// File: rtl/alarm_led_sequencer.sv
// rtl/alarm_led_sequencer.sv - latched alarm driving ten LEDs with an animated pattern
module alarm_led_sequencer
  import alarm_led_pkg::*;
#(
  parameter int TICK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alarm_in,
  input  logic       ack,
  input  logic [1:0] mode,
  output logic       led_a,
  output logic       led_b,
  output logic       led_c,
  output logic       led_d,
  output logic       led_e,
  output logic       led_f,
  output logic       led_g,
  output logic       led_h,
  output logic       led_i,
  output logic       led_j,
  output logic       alarm_active,
  output logic       silenced
);

  logic       a_m, a_s, k_m, k_s, k_q;
  logic       ack_p;
  state_t     state, nxt;
  logic [1:0] mode_q;
  logic [9:0] led, led_nxt;
  logic       entry, run_nxt, run, tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_m <= 1'b0;
      a_s <= 1'b0;
      k_m <= 1'b0;
      k_s <= 1'b0;
      k_q <= 1'b0;
    end else begin
      a_m <= alarm_in;
      a_s <= a_m;
      k_m <= ack;
      k_s <= k_m;
      k_q <= k_s;
    end
  end

  assign ack_p   = k_s & ~k_q;
  assign run     = (state == ALARM) || (state == LATCHED);
  assign run_nxt = (nxt == ALARM) || (nxt == LATCHED);
  assign entry   = (state == IDLE) && (nxt == ALARM);

  // Prescaler restarts on entry and is parked at zero whenever the pattern is not running.
  alarm_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (run),
    .clr   (entry || !run_nxt),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      mode_q       <= MODE_STEADY;
      led          <= '0;
      alarm_active <= 1'b0;
      silenced     <= 1'b0;
    end else begin
      state        <= nxt;
      led          <= led_nxt;
      alarm_active <= (nxt != IDLE);
      silenced     <= (nxt == SILENCED);
      if (entry) mode_q <= mode;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:     if (a_s) nxt = ALARM;
      ALARM: begin
        if (ack_p)     nxt = a_s ? SILENCED : IDLE;
        else if (!a_s) nxt = LATCHED;
      end
      LATCHED: begin
        if (ack_p)    nxt = IDLE;
        else if (a_s) nxt = ALARM;
      end
      SILENCED: if (!a_s) nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  always_comb begin
    led_nxt = '0;
    if (entry)        led_nxt = pat_init(mode);
    else if (run_nxt) led_nxt = tick ? pat_step(mode_q, led) : led;
  end

  assign {led_j, led_i, led_h, led_g, led_f, led_e, led_d, led_c, led_b, led_a} = led;

endmodule

// File: tb/tb_alarm_led_sequencer.sv
// tb/tb_alarm_led_sequencer.sv - directed self-checking bench for alarm_led_sequencer
module tb_alarm_led_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       alarm_in;
  logic       ack;
  logic [1:0] mode;
  logic       led_a, led_b, led_c, led_d, led_e, led_f, led_g, led_h, led_i, led_j;
  logic       alarm_active, silenced;
  logic [9:0] led;
  int         nvec = 0;
  int         nerr = 0;

  assign led = {led_j, led_i, led_h, led_g, led_f, led_e, led_d, led_c, led_b, led_a};

  always #5 clk = ~clk;

  alarm_led_sequencer #(.TICK_DIV(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alarm_in     (alarm_in),
    .ack          (ack),
    .mode         (mode),
    .led_a        (led_a),
    .led_b        (led_b),
    .led_c        (led_c),
    .led_d        (led_d),
    .led_e        (led_e),
    .led_f        (led_f),
    .led_g        (led_g),
    .led_h        (led_h),
    .led_i        (led_i),
    .led_j        (led_j),
    .alarm_active (alarm_active),
    .silenced     (silenced)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    alarm_in = 1'b0;
    cyc(4);
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    cyc(3);
    nvec++;
    if (alarm_active !== 1'b0 || led !== 10'h000) begin
      nerr++;
      $display("FAIL go_idle active=%b led=%h required active=0 led=000", alarm_active, led);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; alarm_in = 1'b0; ack = 1'b0; mode = 2'd0;
    cyc(3);
    rst_n = 1'b1;
    cyc(20);
    nvec++;
    if (led !== 10'h000 || alarm_active !== 1'b0 || silenced !== 1'b0) begin
      nerr++;
      $display("FAIL reset_idle led=%h active=%b sil=%b required 000/0/0", led, alarm_active, silenced);
    end
  endtask

  task automatic test_chase();
    logic [9:0] exp;
    mode = 2'd2;
    alarm_in = 1'b1;
    cyc(2);
    nvec++;
    if (led !== 10'h000 || alarm_active !== 1'b0) begin
      nerr++;
      $display("FAIL chase_latency led=%h active=%b required 000/0", led, alarm_active);
    end
    cyc(1);
    nvec++;
    if (led !== 10'h001 || alarm_active !== 1'b1) begin
      nerr++;
      $display("FAIL chase_entry led=%h active=%b required 001/1", led, alarm_active);
    end
    cyc(3);
    nvec++;
    if (led !== 10'h001) begin
      nerr++;
      $display("FAIL chase_hold led=%h required 001", led);
    end
    exp = 10'h001;
    cyc(1);
    for (int i = 1; i <= 10; i++) begin
      if (i > 1) cyc(4);
      exp = {exp[8:0], exp[9]};
      nvec++;
      if (led !== exp) begin
        nerr++;
        $display("FAIL chase_step%0d led=%h required %h", i, led, exp);
      end
    end
    nvec++;
    if (led !== 10'h001) begin
      nerr++;
      $display("FAIL chase_wrap led=%h required 001", led);
    end
    go_idle();
  endtask

  task automatic test_blink_latch();
    mode = 2'd1;
    alarm_in = 1'b1;
    cyc(3);
    nvec++;
    if (led !== 10'h3FF) begin nerr++; $display("FAIL blink_entry led=%h required 3ff", led); end
    cyc(3);
    alarm_in = 1'b0;
    cyc(1);
    nvec++;
    if (led !== 10'h000) begin nerr++; $display("FAIL blink_step1 led=%h required 000", led); end
    cyc(2);
    nvec++;
    if (alarm_active !== 1'b1 || silenced !== 1'b0 || led !== 10'h000) begin
      nerr++;
      $display("FAIL latched_state active=%b sil=%b led=%h required 1/0/000", alarm_active, silenced, led);
    end
    cyc(2);
    nvec++;
    if (led !== 10'h3FF) begin nerr++; $display("FAIL latched_blink2 led=%h required 3ff", led); end
    cyc(4);
    nvec++;
    if (led !== 10'h000) begin nerr++; $display("FAIL latched_blink3 led=%h required 000", led); end
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    cyc(1);
    nvec++;
    if (alarm_active !== 1'b1) begin nerr++; $display("FAIL ack_early active=%b required 1", alarm_active); end
    cyc(1);
    nvec++;
    if (alarm_active !== 1'b0 || led !== 10'h000) begin
      nerr++;
      $display("FAIL ack_idle active=%b led=%h required 0/000", alarm_active, led);
    end
  endtask

  task automatic test_silence();
    mode = 2'd3;
    alarm_in = 1'b1;
    cyc(3);
    nvec++;
    if (led !== 10'h155) begin nerr++; $display("FAIL alt_entry led=%h required 155", led); end
    cyc(4);
    nvec++;
    if (led !== 10'h2AA) begin nerr++; $display("FAIL alt_step led=%h required 2aa", led); end
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    cyc(2);
    nvec++;
    if (led !== 10'h000 || silenced !== 1'b1 || alarm_active !== 1'b1) begin
      nerr++;
      $display("FAIL silence led=%h sil=%b active=%b required 000/1/1", led, silenced, alarm_active);
    end
    ack = 1'b1;
    cyc(10);
    ack = 1'b0;
    nvec++;
    if (led !== 10'h000 || silenced !== 1'b1) begin
      nerr++;
      $display("FAIL silence_held_ack led=%h sil=%b required 000/1", led, silenced);
    end
    alarm_in = 1'b0;
    cyc(3);
    nvec++;
    if (silenced !== 1'b0 || alarm_active !== 1'b0) begin
      nerr++;
      $display("FAIL silence_release sil=%b active=%b required 0/0", silenced, alarm_active);
    end
  endtask

  task automatic test_mode_latch();
    mode = 2'd0;
    alarm_in = 1'b1;
    cyc(3);
    nvec++;
    if (led !== 10'h3FF) begin nerr++; $display("FAIL steady_entry led=%h required 3ff", led); end
    mode = 2'd2;
    cyc(9);
    nvec++;
    if (led !== 10'h3FF) begin nerr++; $display("FAIL steady_mode_ignored led=%h required 3ff", led); end
    go_idle();
    alarm_in = 1'b1;
    cyc(3);
    nvec++;
    if (led !== 10'h001) begin nerr++; $display("FAIL reentry_chase led=%h required 001", led); end
  endtask

  task automatic test_reset_mid();
    cyc(16);
    nvec++;
    if (led !== 10'h010) begin nerr++; $display("FAIL mid_chase led=%h required 010", led); end
    #2;
    rst_n = 1'b0;
    #1;
    nvec++;
    if (led !== 10'h000 || alarm_active !== 1'b0 || silenced !== 1'b0) begin
      nerr++;
      $display("FAIL async_reset led=%h active=%b sil=%b required 000/0/0", led, alarm_active, silenced);
    end
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    nvec++;
    if (led !== 10'h000) begin nerr++; $display("FAIL post_reset_latency led=%h required 000", led); end
    cyc(1);
    nvec++;
    if (led !== 10'h001 || alarm_active !== 1'b1) begin
      nerr++;
      $display("FAIL post_reset_entry led=%h active=%b required 001/1", led, alarm_active);
    end
  endtask

  initial begin
    test_reset();
    test_chase();
    test_blink_latch();
    test_silence();
    test_mode_latch();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
